// File: rtl/sar5_pkg.sv
// Shared SAR frame definitions. The conversion controller and the decimator
// both import this package so that their phase counters count the same frame.
package sar5_pkg;

   localparam int CODE_W       = 5;
   localparam int CONV_CYCLES  = CODE_W + 1;
   localparam int PHASE_RELOAD = CODE_W;
   localparam int PHASE_W      = $clog2(CONV_CYCLES);

   typedef logic [PHASE_W-1:0] phase_t;

   // Bit width needed to index 'value' items, never less than one bit
   function automatic int clog2_min1(input int value);
      if (value <= 1) begin
         return 1;
      end else begin
         return $clog2(value);
      end
   endfunction

endpackage

// File: rtl/sar5_result_fifo.sv
// Show-ahead result FIFO: the head entry is visible on rd_data whenever the
// FIFO is not empty. A push on a full FIFO is accepted only when a pop
// happens on the same edge; otherwise it is dropped (the caller flags it).
module sar5_result_fifo #(
   parameter int DATA_W = 7,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] rd_data
);
   import sar5_pkg::*;

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              pop_ok_s;
   logic              push_ok_s;

   // Qualify requests: pop needs data, push needs room or a same-edge pop
   always_comb begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
      if (count_r != {CNT_W{1'b0}}) begin
         pop_ok_s = pop;
      end else begin
         pop_ok_s = 1'b0;
      end
      if ((count_r != CNT_FULL) || pop_ok_s) begin
         push_ok_s = push;
      end else begin
         push_ok_s = 1'b0;
      end
   end

   // Storage write; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
         wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
   end

   // Read pointer advances on every accepted pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_r <= {PTR_W{1'b0}};
      end else if (pop_ok_s) begin
         rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
   end

   // Occupancy: simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign full    = (count_r == CNT_FULL);
   assign empty   = (count_r == {CNT_W{1'b0}});
   assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/sar5_decimator.sv
// Oversampling decimator behind the 5-bit SAR controller. Tracks the SAR
// frame with its own phase counter, samples the final code at phase 0,
// sums 2**LOG2_AVG codes and queues each sum in a show-ahead result FIFO.
module sar5_decimator #(
   parameter int CODE_W     = sar5_pkg::CODE_W,
   parameter int LOG2_AVG   = 2,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [CODE_W-1:0]          sar_code,
   output logic [CODE_W+LOG2_AVG-1:0] data_out,
   output logic                       data_valid,
   input  logic                       data_ready,
   output logic                       overrun
);
   import sar5_pkg::*;

   localparam int SUM_W = CODE_W + LOG2_AVG;
   localparam int CNT_W = clog2_min1(2 ** LOG2_AVG);
   localparam int PH_W  = clog2_min1(CODE_W + 1);
   localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(CODE_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((2 ** LOG2_AVG) - 1);

   logic [PH_W-1:0]  phase_r;
   logic [SUM_W-1:0] acc_r;
   logic [CNT_W-1:0] sample_cnt_r;
   logic             overrun_r;

   logic             capture_s;
   logic             last_s;
   logic             pop_s;
   logic             drop_s;
   logic [SUM_W-1:0] sum_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [SUM_W-1:0] fifo_rd_data_s;

   // Capture decode, running sum and FIFO handshake terms
   always_comb begin
      capture_s = 1'b0;
      last_s    = 1'b0;
      sum_s     = acc_r + SUM_W'(sar_code);
      pop_s     = (~fifo_empty_s) & data_ready;
      if (phase_r == {PH_W{1'b0}}) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end
      if (capture_s && (sample_cnt_r == CNT_LAST)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
      drop_s = last_s & fifo_full_s & ~pop_s;
   end

   // Phase counter mirrors the SAR controller frame: CODE_W down to 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase_r <= PH_RELOAD;
      end else if (phase_r == {PH_W{1'b0}}) begin
         phase_r <= PH_RELOAD;
      end else begin
         phase_r <= phase_r - PH_W'(1);
      end
   end

   // Accumulate captured codes; the last one of a group goes to the FIFO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_r        <= {SUM_W{1'b0}};
         sample_cnt_r <= {CNT_W{1'b0}};
      end else if (capture_s) begin
         if (last_s) begin
            acc_r        <= {SUM_W{1'b0}};
            sample_cnt_r <= {CNT_W{1'b0}};
         end else begin
            acc_r        <= sum_s;
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
         end
      end
   end

   // Sticky flag for a result lost on a full FIFO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end
   end

   sar5_result_fifo #(
      .DATA_W (SUM_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (last_s),
      .push_data (sum_s),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .rd_data   (fifo_rd_data_s)
   );

   assign data_out   = fifo_rd_data_s;
   assign data_valid = ~fifo_empty_s;
   assign overrun    = overrun_r;

endmodule
